// File: rtl/mxn_sched_pkg.sv
// Shared types and helpers for the MxN pipeline scheduler.
//   src_t  : source tag of a word (requester 0 or requester 1)
//   occ_w  : width of an occupancy counter able to hold 0..n
package mxn_sched_pkg;

    typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;

    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mxn_pipeline_sched_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   req[1:0]  in   request vector, bit i belongs to requester i
//   en        in   grant enable; no grant bit is raised while low
//   lp        in   last-grant pointer; on a tie requester !lp wins
//   gnt[1:0]  out  one-hot grant (all zero when disabled or idle)
//   gnt_idx   out  index of the would-be winner (valid when any req set)
module rr_arb2
    import mxn_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  logic       lp,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    src_t winner;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        winner = SRC0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            winner = src_t'(~lp);
        end else if (req[1]) begin
            winner = SRC1;
        end
        if (en && (req != 2'b00)) begin
            gnt = (winner == SRC1) ? 2'b10 : 2'b01;
        end
    end

    assign gnt_idx = winner;

endmodule

// File: rtl/mxn_pipeline_sched.sv
// Round-robin scheduler feeding one M-bit, N-stage shift pipeline from two
// requesters. Each stage carries a valid bit, a source tag and a data word;
// the whole pipeline stalls on downstream backpressure and can be flushed.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid[1:0]        per-requester word available
//   req_data0/req_data1   requester words
//   req_ready[1:0]        per-requester accept (one-hot or zero)
//   flush                 drop every in-flight word on the next edge
//   out_valid/out_data/out_src  stage N contents
//   out_ready             downstream accepts stage N
//   occupancy             number of valid stages, 0..N
module mxn_pipeline_sched
    import mxn_sched_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [M-1:0]          req_data0,
    input  logic [M-1:0]          req_data1,
    output logic [1:0]            req_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [M-1:0]          out_data,
    output logic                  out_src,
    input  logic                  out_ready,
    output logic [occ_w(N)-1:0]   occupancy
);

    localparam int CW = occ_w(N);

    // Stage k (1-based) lives at index k-1; index N-1 is the output stage.
    logic [N-1:0]   v_q, v_d, v_sh;
    logic [N-1:0]   src_q, src_d, src_sh;
    logic [N*M-1:0] data_q, data_d, data_sh;
    logic           lp_q, lp_d;
    logic [CW-1:0]  occ_q, occ_d;

    logic advance, accept, xfer, gnt_idx;

    // Shift whenever the output stage is empty or is being drained.
    assign advance = !v_q[N-1] || out_ready;

    // rst_n gates the enable so nothing is offered while reset is held.
    rr_arb2 u_arb (
        .req     (req_valid),
        .en      (advance && !flush && rst_n),
        .lp      (lp_q),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign accept = |(req_valid & req_ready);
    assign xfer   = v_q[N-1] && out_ready;

    // Shifted view of the stage array: stage 1 takes the granted word (or a
    // bubble), every later stage takes its predecessor.
    assign v_sh[0]          = accept;
    assign src_sh[0]        = gnt_idx;
    assign data_sh[M-1:0]   = gnt_idx ? req_data1 : req_data0;

    generate
        for (genvar k = 1; k < N; k++) begin : g_shift
            assign v_sh[k]           = v_q[k-1];
            assign src_sh[k]         = src_q[k-1];
            assign data_sh[k*M +: M] = data_q[(k-1)*M +: M];
        end
    endgenerate

    always_comb begin
        v_d    = v_q;
        src_d  = src_q;
        data_d = data_q;
        lp_d   = lp_q;
        occ_d  = occ_q;
        if (flush) begin
            // Only the valid bits and count are cleared; tags, data and the
            // pointer keep their values.
            v_d   = '0;
            occ_d = '0;
        end else begin
            if (advance) begin
                v_d    = v_sh;
                src_d  = src_sh;
                data_d = data_sh;
            end
            if (accept) begin
                lp_d = gnt_idx;
            end
            occ_d = occ_q + CW'(accept) - CW'(xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data and tag registers are reset as well so the output
            // word reads a defined 0 straight after reset.
            v_q    <= '0;
            src_q  <= '0;
            data_q <= '0;
            lp_q   <= 1'b1;
            occ_q  <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values.
            v_q    <= v_d;
            src_q  <= src_d;
            data_q <= data_d;
            lp_q   <= lp_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = v_q[N-1];
    assign out_src   = src_q[N-1];
    assign out_data  = data_q[(N-1)*M +: M];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_mxn_pipeline_sched.sv
module tb_mxn_pipeline_sched;

    localparam int M  = 3;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [M-1:0]  req_data0, req_data1;
    logic [1:0]    req_ready;
    logic          flush;
    logic          out_valid;
    logic [M-1:0]  out_data;
    logic          out_src;
    logic          out_ready;
    logic [CW-1:0] occupancy;

    int total = 0;
    int bad   = 0;

    // Reference model: an array of N slots, slot N-1 is the output stage.
    bit         m_v   [N];
    bit         m_src [N];
    bit [M-1:0] m_data[N];
    bit         m_lp;

    always #5 clk = ~clk;

    mxn_pipeline_sched #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    function automatic logic [1:0] exp_ready();
        bit adv;
        adv = !m_v[N-1] || out_ready;
        if (!rst_n || flush || !adv || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return m_lp ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    function automatic int exp_occ();
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(m_v[k]);
        return c;
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic step();
        logic [1:0] rr;
        bit adv;
        rr  = exp_ready();
        adv = !m_v[N-1] || out_ready;
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_v[k] = 0; m_src[k] = 0; m_data[k] = '0;
            end
            m_lp = 1;
        end else if (flush) begin
            for (int k = 0; k < N; k++) m_v[k] = 0;
        end else if (adv) begin
            for (int k = N - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_src[k] = m_src[k-1]; m_data[k] = m_data[k-1];
            end
            m_v[0] = (rr != 2'b00);
            if (rr != 2'b00) begin
                m_src[0]  = rr[1];
                m_data[0] = rr[1] ? req_data1 : req_data0;
                m_lp      = rr[1];
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req_valid = 2'b01;
        step();
        step();
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (occupancy !== CW'(0)) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (out_data !== '0 || out_src !== 1'b0) begin bad++; $display("FAIL reset_out_word got=%0d/%b exp=0/0", out_data, out_src); end
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL post_reset_ready got=%b exp=01", req_ready); end
    endtask

    task automatic test_alternate();
        do_reset();
        req_valid = 2'b11; req_data0 = 3'h1; req_data1 = 3'h6; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < N) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alt_early c=%0d got=%b exp=0", c, out_valid); end
            end else begin
                total++;
                if (out_valid !== 1'b1 || out_src !== 1'((c - N) % 2) || out_data !== (((c - N) % 2) ? 3'h6 : 3'h1)) begin
                    bad++;
                    $display("FAIL alt_seq c=%0d got=v%b s%b d%0d exp=v1 s%0d d%0d", c, out_valid, out_src, out_data,
                             (c - N) % 2, ((c - N) % 2) ? 6 : 1);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [M-1:0] q[$];
        logic [M-1:0] w;
        do_reset();
        out_ready = 1'b0; req_valid = 2'b01;
        for (int i = 0; i < N; i++) begin
            w = M'($urandom); req_data0 = w; q.push_back(w);
            step();
        end
        req_data0 = M'($urandom);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (occupancy !== CW'(N) || req_ready !== 2'b00 || out_valid !== 1'b1 || out_data !== q[0]) begin
                bad++;
                $display("FAIL stall_hold i=%0d got=occ%0d rdy%b v%b d%0d exp=occ%0d rdy00 v1 d%0d",
                         i, occupancy, req_ready, out_valid, out_data, N, q[0]);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01 || out_data !== q[0]) begin bad++; $display("FAIL stall_release got=rdy%b d%0d exp=rdy01 d%0d", req_ready, out_data, q[0]); end
        q.push_back(req_data0);
        step();
        req_valid = 2'b00;
        for (int i = 1; i <= N; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== q[i]) begin
                bad++; $display("FAIL stall_drain i=%0d got=v%b d%0d exp=v1 d%0d", i, out_valid, out_data, q[i]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_data0 = M'(i + 2);
            step();
        end
        req_valid = 2'b11; flush = 1'b1;
        #1;
        total++; if (req_ready !== 2'b00 || occupancy !== CW'(3)) begin bad++; $display("FAIL flush_cycle got=rdy%b occ%0d exp=rdy00 occ3", req_ready, occupancy); end
        step();
        flush = 1'b0;
        #1;
        total++; if (occupancy !== CW'(0) || out_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=occ%0d v%b exp=occ0 v0", occupancy, out_valid); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL flush_lp got=%b exp=10", req_ready); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; req_valid = 2'b01;
        req_data0 = 3'h5; step();
        req_data0 = 3'h3; step();
        req_valid = 2'b00; step(); step();
        #1;
        total++; if (occupancy !== CW'(2) || out_valid !== 1'b1 || out_data !== 3'h5) begin bad++; $display("FAIL mid_prestall got=occ%0d v%b d%0d exp=occ2 v1 d5", occupancy, out_valid, out_data); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req_valid = 2'b11;
        #1;
        total++;
        if (out_valid !== 1'b0 || occupancy !== CW'(0) || out_data !== '0 || out_src !== 1'b0 || req_ready !== 2'b01) begin
            bad++;
            $display("FAIL mid_reset got=v%b occ%0d d%0d s%b rdy%b exp=v0 occ0 d0 s0 rdy01", out_valid, occupancy, out_data, out_src, req_ready);
        end
        idle_inputs();
    endtask

    task automatic test_rr_only1();
        do_reset();
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rr_only1 i=%0d got=%b exp=10", i, req_ready); end
            step();
        end
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rr_tie got=%b exp=01", req_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom);
            req_data0 = M'($urandom);
            req_data1 = M'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            #1;
            total++;
            if (req_ready !== exp_ready() || out_valid !== m_v[N-1] || occupancy !== CW'(exp_occ())) begin
                bad++;
                $display("FAIL rand_ctrl c=%0d got=rdy%b v%b occ%0d exp=rdy%b v%b occ%0d",
                         c, req_ready, out_valid, occupancy, exp_ready(), m_v[N-1], exp_occ());
            end
            if (m_v[N-1]) begin
                total++;
                if (out_data !== m_data[N-1] || out_src !== m_src[N-1]) begin
                    bad++;
                    $display("FAIL rand_word c=%0d got=d%0d s%b exp=d%0d s%b", c, out_data, out_src, m_data[N-1], m_src[N-1]);
                end
            end
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 0; m_src[k] = 0; m_data[k] = '0;
        end
        m_lp = 1;
        #1;
        test_reset();
        test_alternate();
        test_stall();
        test_flush();
        test_reset_mid();
        test_rr_only1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mxn_pipeline_sched.md
# mxn_pipeline_sched

Round-robin scheduler that shares one M-bit wide, N-stage shift pipeline between two requesters. It arbitrates a single word per cycle into stage 1 and tracks a valid bit and source tag per stage. It stalls the whole pipeline on downstream backpressure and supports a synchronous flush. It sits in front of the MxN pipeline datapath and is the only writer of its stage-1 input.

## Interface
- M, 3, data width in bits (≥1)
- N, 4, pipeline depth in stages (≥1)
- CW, $clog2(N+1), occupancy counter width (derived localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous and active-low; one clock, sampled on rising clk edge
- req_valid  in  2  per-requester word available; bit i belongs to requester i
- req_data0  in  M  requester 0 word
- req_data1  in  M  requester 1 word
- req_ready  out  2  per-requester accept; handshake on req_valid[i] & req_ready[i]
- flush  in  1  discard all in-flight words
- out_valid  out  1  stage N holds a valid word
- out_data  out  M  stage N word
- out_src  out  1  stage N source tag (0 or 1)
- out_ready  in  1  downstream accepts stage N
- occupancy  out  CW  count of valid stages, 0..N

## Operation
- Per stage k=1..N: the scheduler holds v[k], src[k] and data[k]. out_* are driven from stage N.
- advance = !out_valid | out_ready. When advance is high, every stage shifts one position. Stage 1 loads the granted word, or a bubble if there is no grant. When advance is low, every stage holds.
- Arbitration is round-robin with a 1-bit last-grant pointer lp.
  - Only one requester valid: it wins.
  - Both requesters valid: requester !lp wins.
  - lp updates to the winner only on a completed handshake.
- req_ready[i] = advance & !flush & (grant == i). At most one bit is high. req_ready is combinational from req_valid, lp, out_valid, out_ready and flush.
- flush has priority over everything else:
  - On the next edge, every v[k] clears to 0 and occupancy goes to 0.
  - No handshake occurs in the flush cycle.
  - lp and data registers are unchanged.
  - out_valid may be high in the flush cycle; if out_ready is also high, downstream counts that word as transferred.
- Occupancy update on each edge: +1 if a word enters stage 1, −1 if stage N is transferred out (out_valid & out_ready), net 0 if both happen.
- Bubbles: the pipeline does not collapse bubbles. An empty stage still takes N advancing cycles to drain.

## Timing
- Reset values: v[*]=0, out_valid=0, occupancy=0, lp=1 (so requester 0 wins the first tie). out_data and out_src are don't-care while out_valid=0. The bench checks them as 0 because data and tag registers also reset to 0.
- Latency: a handshake in cycle c gives out_valid in cycle c+N when no stall occurs. Each stalled cycle adds 1.
- Throughput: one word per cycle while out_ready=1.
- Stall: while out_valid & !out_ready, all stages and outputs hold stable and req_ready=0.
- Reset mid-operation: rst_n low on an edge clears the whole state regardless of flush or stall. req_ready is 0 while rst_n is low.
- Boundary cases:
  - N=1: stage 1 is also stage N; the advance rule still holds.
  - Full pipeline (occupancy=N) with out_ready=1 accepts a new word in the same cycle.

## Structure
- Package mxn_sched_pkg holds:
  - typedef enum logic {SRC0=1'b0, SRC1=1'b1} src_t
  - function occ_w(N) returning $clog2(N+1)
- Sub-module rr_arb2 contains the two-way round-robin arbiter:
  - inputs: req[1:0], en, lp
  - outputs: gnt[1:0], gnt_idx
- The stage array lives in the top level as packed v/src/data vectors, shifted with a generate loop.

## Test plan
- Reset with M=3, N=4 → out_valid=0, occupancy=0, req_ready=00. After rst_n=1 with req_valid=01 → req_ready=01.
- Both requesters always valid, data0=3'h1, data1=3'h6, out_ready=1 → out_src sequence 0,1,0,1… starting in cycle 4 after the first handshake. out_data alternates 1,6.
- Fill 4 words, hold out_ready=0 for 5 cycles → occupancy=4, req_ready=00, outputs stable. Release out_ready → 4 words out in order, with a new accept in the first release cycle.
- Flush with occupancy=3 and req_valid=11 → no handshake that cycle; next cycle occupancy=0 and out_valid=0; lp unchanged.
- Assert rst_n=0 for one cycle with occupancy=2 mid-stall → all outputs return to reset values on the following cycle.
- Only requester 1 valid for 3 cycles, then both valid → grants go 1,1,1, then 0 (lp=1 gives priority to requester 0).
